adc_conv_sequencer: RTL and testbench
=====================================

Name: adc_conv_sequencer

Overview:
- Sequences the pipelined thermometer-to-binary ADC digitiser: generates the phi1/phi2 phase strobes, flushes and fills the stage pipeline, then captures one 13-bit code per conversion period.
- Supports bursts of N conversions or continuous running.
- Delivers samples over a valid/ready interface to the readout logic, with overrun counting.

Parameters:
- FLUSH_PERIODS, 2, phase periods pipe_rst is held high after start
- PIPE_DEPTH, 6, phase periods of pipeline fill before the first valid capture (5 stage delays + output register)
- OVR_W, 8, width of the saturating overrun counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a sequence (IDLE only)
- stop  in  1  one-cycle pulse; aborts any active sequence
- div_cfg  in  8  clk cycles per conversion period; latched at start
- burst_len  in  16  conversions per burst; 0 = continuous; latched at start
- adc_code  in  13  assembled code from the digitiser datapath
- phi1_en  out  1  phase-1 strobe to the datapath
- phi2_en  out  1  phase-2 strobe to the datapath
- pipe_rst  out  1  datapath pipeline reset
- sample_data  out  13  captured code
- sample_valid  out  1  sample_data is valid
- sample_ready  in  1  consumer accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- ovr_cnt  out  OVR_W  saturating count of dropped samples
- oor_flag  out  1  sticky out-of-range flag (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- States: IDLE, FLUSH, FILL, RUN, DONE.
- IDLE: start → FLUSH next cycle. Latch div_eff = max(div_cfg, 4) and burst_len. Clear pcnt.
- Phase generator runs in FLUSH, FILL and RUN.
  - pcnt counts 0..div_eff-1 and wraps.
  - phi1_en = (pcnt==0); phi2_en = (pcnt==div_eff/2, floor). Both registered; never high together.
- FLUSH: pipe_rst=1 for FLUSH_PERIODS full periods, then → FILL on the pcnt wrap.
- FILL: pipe_rst=0 for PIPE_DEPTH periods, then → RUN on the wrap.
- RUN: on each pcnt==div_eff-1, capture adc_code (the capture event). sample_valid rises the next cycle. Increment the sample count.
  - When count==burst_len (burst_len≠0), → DONE after that capture.
  - burst_len=0: run until stop.
- DONE: done=1 for one cycle, → IDLE. Phases stop.
- stop in FLUSH/FILL/RUN/DONE → IDLE next cycle.
  - Phases and pipe_rst go low; no done pulse.
  - Any held sample stays valid until accepted.
- start while busy is ignored; start and stop together in IDLE: stop wins (stay IDLE).
- Output register is one entry:
  - Transfer when sample_valid && sample_ready.
  - Capture with the register empty, or being accepted in the same cycle: load the new code, valid=1.
  - Capture while valid && !sample_ready: drop the new code, keep the old data, ovr_cnt+1 (saturates at all-ones).
- Sample counter is 16-bit and does not wrap in continuous mode; it stops counting at 0xFFFF.
- Async rst mid-sequence: immediate return to the reset values, including clearing the held sample and ovr_cnt.

Optional Feature:
- Macro ADC_SEQ_RANGE_CHECK_EN.
- Defined: each capture compares adc_code > MAX_CODE (7510 = 13·512+5·128+5·32+5·8+14). If greater, oor_flag is set sticky until rst or the next start. The code is still delivered.
- Undefined: oor_flag tied 0; no comparator.

Decomposition:
- Package adc_seq_pkg holds:
  - state enum
  - CODE_W=13
  - MAX_CODE=7510
  - MIN_DIV=4
- Sub-module adc_phase_gen holds the pcnt counter, div_eff clamp, phi1/phi2 strobes and the period-wrap pulse.
- FSM, output register and counters stay in the top.

Test Plan:
- rst, start with div_cfg=4, burst_len=3, ready=1:
  - pipe_rst high 8 clks
  - FILL 24 clks
  - three sample_valid pulses 4 clks apart with data = adc_code at each capture
  - done one cycle after the 3rd capture, then busy=0
- div_cfg=2 → phi1_en period 4 clks; phi2_en at pcnt==2; never overlapping phi1_en.
- burst_len=3, sample_ready=0 throughout:
  - first code held unchanged
  - ovr_cnt=2
  - raising ready then delivers exactly one sample
- burst_len=0, stop after 5 captures:
  - IDLE next clk; phi strobes cease
  - done stays 0
  - held sample still valid until ready
- rst asserted mid-FILL: all outputs 0 in the same cycle (asynchronous); a later start restarts from FLUSH.
- With ADC_SEQ_RANGE_CHECK_EN: adc_code=7600 during a capture → oor_flag=1 and it stays 1. Without the macro: oor_flag=0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC conversion sequencer.
//   - seq_state_e : sequencer FSM states
//   - CODE_W      : width of one digitiser code
//   - MAX_CODE    : largest legal code (13*512 + 5*128 + 5*32 + 5*8 + 14)
//   - MIN_DIV     : shortest allowed conversion period in clk cycles
//   - clamp_div   : applies the MIN_DIV floor to a requested divider
package adc_seq_pkg;

    localparam int CODE_W   = 13;
    localparam int MAX_CODE = 7510;
    localparam int MIN_DIV  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    function automatic logic [7:0] clamp_div(input logic [7:0] d);
        return (d < 8'(MIN_DIV)) ? 8'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/adc_phase_gen.sv
// Phase generator for the ADC conversion sequencer.
// Runs a period counter pcnt over 0..div_eff-1 and produces the phi1/phi2
// strobes plus a one-cycle wrap pulse on the last cycle of each period.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : latch clamp(div_cfg_i) as the period length
//   div_cfg_i   : requested clk cycles per conversion period
//   en_d_i      : phases are active in the next cycle
//   phi1_o      : high while pcnt == 0
//   phi2_o      : high while pcnt == div_eff/2
//   wrap_o      : high while pcnt == div_eff-1 (last cycle of a period)
module adc_phase_gen
    import adc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] div_cfg_i,
    input  logic       en_d_i,
    output logic       phi1_o,
    output logic       phi2_o,
    output logic       wrap_o
);

    logic [7:0] div_q, div_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic       en_q;
    logic       phi1_q, phi2_q;

    assign div_d  = load_i ? clamp_div(div_cfg_i) : div_q;
    assign wrap_o = en_q && (pcnt_q == div_q - 8'd1);

    // pcnt restarts at 0 on the first active cycle and on every wrap,
    // and is held at 0 while the phases are stopped.
    always_comb begin
        pcnt_d = pcnt_q + 8'd1;
        if (!en_d_i || !en_q || wrap_o)
            pcnt_d = '0;
    end

    // Strobes are registered from the next-cycle count so they line up
    // with pcnt; div_eff/2 >= 2 keeps phi2 clear of phi1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 8'(MIN_DIV);
            pcnt_q <= '0;
            en_q   <= 1'b0;
            phi1_q <= 1'b0;
            phi2_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pcnt_q <= pcnt_d;
            en_q   <= en_d_i;
            phi1_q <= en_d_i && (pcnt_d == 8'd0);
            phi2_q <= en_d_i && (pcnt_d == (div_d >> 1));
        end
    end

    assign phi1_o = phi1_q;
    assign phi2_o = phi2_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// Sequencer for the pipelined thermometer-to-binary ADC digitiser.
// Flushes the stage pipeline (pipe_rst), lets it fill, then captures one
// code per conversion period into a one-entry valid/ready output register.
// Bursts of burst_len conversions, or continuous when burst_len == 0.
// Optional feature: define ADC_SEQ_RANGE_CHECK_EN to enable the sticky
// out-of-range flag (code > MAX_CODE); otherwise oor_flag is tied low.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, stop     : one-cycle control pulses (stop wins)
//   div_cfg         : clk cycles per conversion period (latched at start)
//   burst_len       : conversions per burst, 0 = continuous (latched at start)
//   adc_code        : assembled code from the datapath
//   phi1_en/phi2_en : phase strobes to the datapath
//   pipe_rst        : datapath pipeline reset
//   sample_data/sample_valid/sample_ready : readout handshake
//   busy, done      : status; done pulses once at burst completion
//   ovr_cnt         : saturating count of dropped samples
//   oor_flag        : sticky out-of-range flag
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int FLUSH_PERIODS = 2,
    parameter int PIPE_DEPTH    = 6,
    parameter int OVR_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        div_cfg,
    input  logic [15:0]       burst_len,
    input  logic [CODE_W-1:0] adc_code,
    output logic              phi1_en,
    output logic              phi2_en,
    output logic              pipe_rst,
    output logic [CODE_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic [OVR_W-1:0]  ovr_cnt,
    output logic              oor_flag
);

    seq_state_e        state_q, state_d;
    logic [7:0]        per_q, per_d;
    logic [15:0]       blen_q, blen_d;
    logic [15:0]       scnt_q, scnt_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] data_q, data_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;
    logic              load, capture, last_cap, wrap, ph_en_d;

    adc_phase_gen u_phase (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .div_cfg_i (div_cfg),
        .en_d_i    (ph_en_d),
        .phi1_o    (phi1_en),
        .phi2_o    (phi2_en),
        .wrap_o    (wrap)
    );

    assign load     = (state_q == ST_IDLE) && start && !stop;
    assign capture  = (state_q == ST_RUN) && wrap;
    assign last_cap = capture && (blen_q != 16'd0) &&
                      ((17'(scnt_q) + 17'd1) == 17'(blen_q));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) state_d = ST_FLUSH;
                ST_FLUSH: if (wrap && per_q == 8'(FLUSH_PERIODS - 1)) state_d = ST_FILL;
                ST_FILL:  if (wrap && per_q == 8'(PIPE_DEPTH - 1))    state_d = ST_RUN;
                ST_RUN:   if (last_cap) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state_q != ST_IDLE);
        pipe_rst = (state_q == ST_FLUSH);
        done     = (state_q == ST_DONE);
        ph_en_d  = (state_d == ST_FLUSH) || (state_d == ST_FILL) || (state_d == ST_RUN);
    end

    // Period counter for FLUSH/FILL, burst latch, sample counter, output reg.
    always_comb begin
        per_d = per_q;
        if (state_d != state_q)
            per_d = '0;
        else if (wrap && (state_q == ST_FLUSH || state_q == ST_FILL))
            per_d = per_q + 8'd1;

        blen_d = load ? burst_len : blen_q;

        // Sample count sticks at all-ones in continuous mode.
        scnt_d = scnt_q;
        if (load)
            scnt_d = '0;
        else if (capture && scnt_q != 16'hFFFF)
            scnt_d = scnt_q + 16'd1;

        // A capture only lands if the slot is free or draining this cycle;
        // otherwise the new code is dropped and counted.
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (capture) begin
            if (!valid_q || sample_ready) begin
                valid_d = 1'b1;
                data_d  = adc_code;
            end else if (ovr_q != '1) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q   <= '0;
            blen_q  <= '0;
            scnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= '0;
        end else begin
            per_q   <= per_d;
            blen_q  <= blen_d;
            scnt_q  <= scnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign ovr_cnt      = ovr_q;

`ifdef ADC_SEQ_RANGE_CHECK_EN
    logic oor_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            oor_q <= 1'b0;
        else if (load)
            oor_q <= 1'b0;
        else if (capture && adc_code > CODE_W'(MAX_CODE))
            oor_q <= 1'b1;
    end
    assign oor_flag = oor_q;
`else
    assign oor_flag = 1'b0;
`endif

endmodule

// File: tb/tb_adc_conv_sequencer.sv
module tb_adc_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [7:0]  div_cfg = 8'd4;
    logic [15:0] burst_len = 16'd0;
    logic [12:0] adc_code = '0;
    logic        sample_ready = 1'b0;
    logic        phi1_en, phi2_en, pipe_rst, sample_valid, busy, done, oor_flag;
    logic [12:0] sample_data;
    logic [7:0]  ovr_cnt;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model: a sequence is described by the cycle index t since
    // start; every phase boundary follows from div_eff arithmetic.
    bit          m_act;
    int          m_t, m_div, m_blen, m_ovr;
    bit          m_v, m_oor;
    logic [12:0] m_d;

    adc_conv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .div_cfg(div_cfg), .burst_len(burst_len), .adc_code(adc_code),
        .phi1_en(phi1_en), .phi2_en(phi2_en), .pipe_rst(pipe_rst),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .done(done),
        .ovr_cnt(ovr_cnt), .oor_flag(oor_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_t = 0; m_div = 4; m_blen = 0; m_ovr = 0;
        m_v = 0; m_oor = 0; m_d = '0;
    endtask

    // Effect of the coming clock edge given this cycle's inputs.
    task automatic model_edge(input bit st, input bit sp, input bit rdy, input logic [12:0] code);
        int  tdone;
        bit  cap;
        tdone = 8*m_div + m_blen*m_div;
        cap = m_act && (m_t >= 8*m_div) && ((m_t + 1) % m_div == 0) &&
              (m_blen == 0 || m_t < tdone);
        if (cap) begin
            if (!m_v || rdy) begin m_v = 1; m_d = code; end
            else if (m_ovr < 255) m_ovr++;
`ifdef ADC_SEQ_RANGE_CHECK_EN
            if (code > 13'd7510) m_oor = 1;
`endif
        end else if (m_v && rdy) begin
            m_v = 0;
        end
        if (m_act) begin
            if (sp || (m_blen != 0 && m_t == tdone)) m_act = 0;
            else m_t++;
        end else if (st && !sp) begin
            m_act = 1; m_t = 0;
            m_div = (div_cfg < 4) ? 4 : int'(div_cfg);
            m_blen = int'(burst_len);
            m_oor = 0;
        end
    endtask

    task automatic compare();
        int tdone;
        bit ph;
        tdone = 8*m_div + m_blen*m_div;
        ph = m_act && !(m_blen != 0 && m_t == tdone);
        chk("busy",     busy,     m_act);
        chk("pipe_rst", pipe_rst, m_act && m_t < 2*m_div);
        chk("done",     done,     m_act && m_blen != 0 && m_t == tdone);
        chk("phi1",     phi1_en,  ph && (m_t % m_div == 0));
        chk("phi2",     phi2_en,  ph && (m_t % m_div == m_div/2));
        chk("valid",    sample_valid, m_v);
        if (m_v) chk("data", sample_data, m_d);
        chk("ovr_cnt",  ovr_cnt,  m_ovr);
        chk("oor_flag", oor_flag, m_oor);
    endtask

    // One clock: drive at negedge, predict, check at the next negedge.
    task automatic step(input bit st, input bit sp, input bit rdy);
        logic [12:0] code;
        code = 13'($urandom_range(0, 8191));
        start = st; stop = sp; sample_ready = rdy; adc_code = code;
        model_edge(st, sp, rdy, code);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("rst_data", sample_data, 0);
        rst = 1'b0;

        // Basic burst: div 4, 3 conversions, consumer always ready.
        div_cfg = 8'd4; burst_len = 16'd3;
        step(1, 0, 1);
        repeat (20) step(0, 0, 1);
        step(1, 0, 1);                      // start while busy is ignored
        repeat (40) step(0, 0, 1);

        // start and stop together in IDLE: stop wins.
        step(1, 1, 1);
        step(0, 0, 1);

        // div below the floor clamps to 4.
        div_cfg = 8'd2; burst_len = 16'd2;
        step(1, 0, 1);
        repeat (55) step(0, 0, 1);

        // Consumer stalled: first code held, later ones dropped and counted.
        div_cfg = 8'd5; burst_len = 16'd3;
        step(1, 0, 0);
        repeat (70) step(0, 0, 0);
        repeat (4) step(0, 0, 1);

        // Continuous mode, stop two cycles after the 5th capture.
        div_cfg = 8'd4; burst_len = 16'd0;
        step(1, 0, 0);
        while (m_act && m_t < 53) step(0, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        repeat (2) step(0, 0, 1);

        // Asynchronous reset in the middle of FILL, then restart.
        div_cfg = 8'd4; burst_len = 16'd2;
        step(1, 0, 0);
        while (m_act && m_t < 12) step(0, 0, 0);
        #2 rst = 1'b1;
        #1 model_reset();
        compare();
        chk("arst_data", sample_data, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 1);
        repeat (50) step(0, 0, 1);

        // Randomised sequences with stalls, stray starts/stops and config churn.
        for (int r = 0; r < 25; r++) begin
            div_cfg   = 8'($urandom_range(0, 9));
            burst_len = 16'($urandom_range(0, 4));
            step(1, 0, $urandom_range(0, 2) != 0);
            for (int c = 0; c < 119; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    div_cfg   = 8'($urandom_range(0, 9));
                    burst_len = 16'($urandom_range(0, 4));
                end
                step($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
                     $urandom_range(0, 2) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
